csr_trap_unit: RTL and testbench

// Machine-mode trap/interrupt controller for rv32imac cores, parametrised in external IRQ count and per-line edge/level mode.

---
 rtl/csr_trap_unit.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
// ---------------------------------------------------------------------------
// csr_trap_unit
//
// Machine-mode trap and interrupt controller for an rv32imac core. Holds the
// M-mode trap CSRs (mstatus MIE/MPIE/MPP, mie, mip, mtvec, mepc, mcause,
// mtval), arbitrates synchronous exceptions, mret and external interrupts,
// and drives the fetch redirect. Sits beside decode/execute and supplies the
// CSR read mux.
//
// Parameters
//   NUM_IRQ    number of external IRQ lines (1..16); line k is mie/mip bit
//              16+k and interrupt cause 16+k
//   IRQ_EDGE   per-line mode: 1 = rising-edge latched, 0 = level
//   RESET_VEC  mtvec reset value (bits [1:0] are the reset MODE)
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-low reset
//   csr_addr_i   CSR address
//   csr_wr_en_i  CSR write strobe (data already read-modify-written upstream)
//   csr_data_i   CSR write data
//   csr_data_o   CSR read data, combinational, 0 for unowned addresses
//   exc_valid_i  synchronous exception in the current instruction
//   exc_cause_i  exception code
//   exc_tval_i   trap value for mtval
//   mret_i       mret retiring
//   fet_pc_i     PC of the instruction being trapped/interrupted
//   irq_i        raw IRQ lines, synchronous to clk_i
//   trap_o       trap taken this cycle
//   pc_wr_en_o   fetch redirect strobe (trap or mret)
//   pc_o         redirect target
//   irq_ack_o    one-hot, asserted in the cycle IRQ k is taken
// ---------------------------------------------------------------------------
module csr_trap_unit #(
   parameter int unsigned        NUM_IRQ   = 8,
   parameter logic [NUM_IRQ-1:0] IRQ_EDGE  = '0,
   parameter logic [31:0]        RESET_VEC = 32'h0000_0000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [11:0]        csr_addr_i,
   input  logic               csr_wr_en_i,
   input  logic [31:0]        csr_data_i,
   output logic [31:0]        csr_data_o,
   input  logic               exc_valid_i,
   input  logic [4:0]         exc_cause_i,
   input  logic [31:0]        exc_tval_i,
   input  logic               mret_i,
   input  logic [31:0]        fet_pc_i,
   input  logic [NUM_IRQ-1:0] irq_i,
   output logic               trap_o,
   output logic               pc_wr_en_o,
   output logic [31:0]        pc_o,
   output logic [NUM_IRQ-1:0] irq_ack_o
);

   localparam logic [11:0] CsrMstatus = 12'h300;
   localparam logic [11:0] CsrMie     = 12'h304;
   localparam logic [11:0] CsrMtvec   = 12'h305;
   localparam logic [11:0] CsrMepc    = 12'h341;
   localparam logic [11:0] CsrMcause  = 12'h342;
   localparam logic [11:0] CsrMtval   = 12'h343;
   localparam logic [11:0] CsrMip     = 12'h344;

   typedef enum logic [0:0] {
      StRun      = 1'b0,
      StRedirect = 1'b1
   } state_e;

   state_e state_q, state_d;

   // Architectural state
   logic               mstatus_mie_q, mstatus_mie_d;
   logic               mstatus_mpie_q, mstatus_mpie_d;
   logic [NUM_IRQ-1:0] irq_en_q, irq_en_d;
   logic [31:0]        mtvec_q, mtvec_d;
   logic [31:0]        mepc_q, mepc_d;
   logic [31:0]        mcause_q, mcause_d;
   logic [31:0]        mtval_q, mtval_d;

   // IRQ input pipeline and latched edge requests
   logic [NUM_IRQ-1:0] irq_q, irq_prev_q;
   logic [NUM_IRQ-1:0] edge_pend_q, edge_pend_d;

   logic [NUM_IRQ-1:0] mip_lines;
   logic [NUM_IRQ-1:0] irq_pend;
   logic [NUM_IRQ-1:0] irq_onehot;
   logic [NUM_IRQ-1:0] edge_rise;
   logic [NUM_IRQ-1:0] mip_clr;
   logic [3:0]         irq_idx;
   logic [4:0]         irq_code;

   logic               take_exc, take_mret, take_irq, take_evt;
   logic [31:0]        mtvec_base;
   logic [31:0]        irq_target;
   logic [NUM_IRQ-1:0] ack_int;

   logic               wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mtval, wr_mip;
   logic [31:0]        csr_rdata;

   // ------------------------------------------------------------------------
   // Interrupt pending / selection
   // ------------------------------------------------------------------------
   assign mip_lines = (IRQ_EDGE & edge_pend_q) | (~IRQ_EDGE & irq_q);
   assign irq_pend  = mip_lines & irq_en_q;
   assign edge_rise = IRQ_EDGE & irq_q & ~irq_prev_q;

   // Lowest line number wins: scan downward so the last hit is the lowest.
   always_comb begin
      irq_idx    = '0;
      irq_onehot = '0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (irq_pend[k]) begin
            irq_idx    = 4'(k);
            irq_onehot = '0;
            irq_onehot[k] = 1'b1;
         end
      end
   end

   assign irq_code   = 5'd16 + {1'b0, irq_idx};
   assign mtvec_base = {mtvec_q[31:2], 2'b00};
   assign irq_target = (mtvec_q[1:0] == 2'b01) ? mtvec_base + {25'b0, irq_code, 2'b00}
                                                : mtvec_base;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state. The redirect shadow is always exactly one cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:      if (take_evt) state_d = StRedirect;
         StRedirect: state_d = StRun;
         default:    state_d = StRun;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: event arbitration and outputs. Exception > mret > IRQ; nothing is
   // taken while the redirect shadow is flushed. Outputs are held at 0 while
   // reset is asserted regardless of the other inputs.
   // ------------------------------------------------------------------------
   always_comb begin
      take_exc  = 1'b0;
      take_mret = 1'b0;
      take_irq  = 1'b0;
      if (state_q == StRun) begin
         if (exc_valid_i) begin
            take_exc = 1'b1;
         end else if (mret_i) begin
            take_mret = 1'b1;
         end else if (mstatus_mie_q && (|irq_pend)) begin
            take_irq = 1'b1;
         end
      end
      take_evt = take_exc | take_mret | take_irq;
      ack_int  = take_irq ? irq_onehot : '0;

      trap_o     = 1'b0;
      pc_wr_en_o = 1'b0;
      pc_o       = '0;
      irq_ack_o  = '0;
      if (rst_i) begin
         if (take_exc) begin
            trap_o     = 1'b1;
            pc_wr_en_o = 1'b1;
            pc_o       = mtvec_base;
         end else if (take_mret) begin
            pc_wr_en_o = 1'b1;
            pc_o       = mepc_q;
         end else if (take_irq) begin
            trap_o     = 1'b1;
            pc_wr_en_o = 1'b1;
            pc_o       = irq_target;
            irq_ack_o  = irq_onehot;
         end
      end
   end

   // ------------------------------------------------------------------------
   // CSR write decode. A trap or mret owns mstatus/mepc/mcause/mtval that
   // cycle; mie, mtvec and mip writes still land.
   // ------------------------------------------------------------------------
   always_comb begin
      wr_mstatus = csr_wr_en_i && (csr_addr_i == CsrMstatus) && !take_evt;
      wr_mepc    = csr_wr_en_i && (csr_addr_i == CsrMepc)    && !take_evt;
      wr_mcause  = csr_wr_en_i && (csr_addr_i == CsrMcause)  && !take_evt;
      wr_mtval   = csr_wr_en_i && (csr_addr_i == CsrMtval)   && !take_evt;
      wr_mie     = csr_wr_en_i && (csr_addr_i == CsrMie);
      wr_mtvec   = csr_wr_en_i && (csr_addr_i == CsrMtvec);
      wr_mip     = csr_wr_en_i && (csr_addr_i == CsrMip);
   end

   assign mip_clr = wr_mip ? ~csr_data_i[16 +: NUM_IRQ] : '0;

   // A new rising edge beats a coincident ack or software clear.
   assign edge_pend_d = edge_rise | (edge_pend_q & ~ack_int & ~mip_clr);

   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      irq_en_d       = irq_en_q;
      mtvec_d        = mtvec_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;

      if (wr_mstatus) begin
         mstatus_mie_d  = csr_data_i[3];
         mstatus_mpie_d = csr_data_i[7];
      end
      if (wr_mie) begin
         irq_en_d = csr_data_i[16 +: NUM_IRQ];
      end
      if (wr_mtvec) begin
         mtvec_d[31:2] = csr_data_i[31:2];
         // MODE is WARL: only direct (0) and vectored (1) are accepted.
         if (!csr_data_i[1]) begin
            mtvec_d[1:0] = csr_data_i[1:0];
         end
      end
      if (wr_mepc) begin
         mepc_d = csr_data_i & 32'hFFFF_FFFE;
      end
      if (wr_mcause) begin
         mcause_d = csr_data_i;
      end
      if (wr_mtval) begin
         mtval_d = csr_data_i;
      end

      if (take_exc || take_irq) begin
         mepc_d         = fet_pc_i & 32'hFFFF_FFFE;
         mcause_d       = take_exc ? {27'b0, exc_cause_i} : {1'b1, 26'b0, irq_code};
         mtval_d        = take_exc ? exc_tval_i : 32'h0;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (take_mret) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         irq_en_q       <= '0;
         mtvec_q        <= RESET_VEC;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         irq_q          <= '0;
         irq_prev_q     <= '0;
         edge_pend_q    <= '0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         irq_en_q       <= irq_en_d;
         mtvec_q        <= mtvec_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
         irq_q          <= irq_i;
         irq_prev_q     <= irq_q;
         edge_pend_q    <= edge_pend_d;
      end
   end

   // ------------------------------------------------------------------------
   // CSR read mux. MPP is hardwired to M-mode.
   // ------------------------------------------------------------------------
   always_comb begin
      csr_rdata = '0;
      case (csr_addr_i)
         CsrMstatus: csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
         CsrMie:     csr_rdata[16 +: NUM_IRQ] = irq_en_q;
         CsrMtvec:   csr_rdata = mtvec_q;
         CsrMepc:    csr_rdata = mepc_q;
         CsrMcause:  csr_rdata = mcause_q;
         CsrMtval:   csr_rdata = mtval_q;
         CsrMip:     csr_rdata[16 +: NUM_IRQ] = mip_lines;
         default:    csr_rdata = '0;
      endcase
      csr_data_o = rst_i ? csr_rdata : 32'h0;
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
module tb_csr_trap_unit;

   localparam int unsigned   NI   = 8;
   localparam logic [NI-1:0] EDGE = 8'b0000_0101;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [11:0]   csr_addr;
   logic          csr_wr;
   logic [31:0]   csr_data;
   logic [31:0]   csr_rd;
   logic          exc_valid;
   logic [4:0]    exc_cause;
   logic [31:0]   exc_tval;
   logic          mret;
   logic [31:0]   fet_pc;
   logic [NI-1:0] irq;
   logic          trap_o;
   logic          pc_wr_en_o;
   logic [31:0]   pc_o;
   logic [NI-1:0] irq_ack_o;

   csr_trap_unit #(
      .NUM_IRQ   (NI),
      .IRQ_EDGE  (EDGE),
      .RESET_VEC (32'h0000_0000)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .csr_addr_i  (csr_addr),
      .csr_wr_en_i (csr_wr),
      .csr_data_i  (csr_data),
      .csr_data_o  (csr_rd),
      .exc_valid_i (exc_valid),
      .exc_cause_i (exc_cause),
      .exc_tval_i  (exc_tval),
      .mret_i      (mret),
      .fet_pc_i    (fet_pc),
      .irq_i       (irq),
      .trap_o      (trap_o),
      .pc_wr_en_o  (pc_wr_en_o),
      .pc_o        (pc_o),
      .irq_ack_o   (irq_ack_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h want %08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_mie, m_mpie, m_redir;
   bit [NI-1:0] m_en, m_pend, m_s1, m_s2, edge_mask;
   bit [31:0]   m_mtvec, m_mepc, m_mcause, m_mtval;

   // predicted event for the current cycle: 0 none, 1 exception, 2 mret, 3 irq
   int          e_kind, e_k;
   bit          e_trap, e_pcwr;
   bit [31:0]   e_pc;
   bit [NI-1:0] e_ack;

   bit          obs_trap, obs_pcwr;
   bit [31:0]   obs_pc, obs_rd;
   bit [NI-1:0] obs_ack;

   task automatic model_reset();
      m_mie = 0; m_mpie = 0; m_redir = 0;
      m_en = '0; m_pend = '0; m_s1 = '0; m_s2 = '0;
      m_mtvec = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0;
   endtask

   function automatic bit line_mip(int k);
      return edge_mask[k] ? m_pend[k] : m_s1[k];
   endfunction

   function automatic bit [31:0] m_read(bit [11:0] a);
      bit [31:0] v = 32'h0;
      case (a)
         12'h300: v = 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
         12'h304: v = 32'(m_en) << 16;
         12'h305: v = m_mtvec;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'h343: v = m_mtval;
         12'h344: for (int k = 0; k < NI; k++) v[16 + k] = line_mip(k);
         default: v = 32'h0;
      endcase
      return v;
   endfunction

   task automatic predict();
      bit found = 0;
      e_kind = 0; e_k = 0; e_trap = 0; e_pcwr = 0; e_pc = 0; e_ack = '0;
      if (!m_redir) begin
         if (exc_valid) begin
            e_kind = 1; e_trap = 1; e_pcwr = 1; e_pc = m_mtvec & ~32'h3;
         end else if (mret) begin
            e_kind = 2; e_pcwr = 1; e_pc = m_mepc;
         end else if (m_mie) begin
            for (int k = 0; k < NI && !found; k++) begin
               if (line_mip(k) && m_en[k]) begin
                  found = 1;
                  e_k = k;
               end
            end
            if (found) begin
               e_kind = 3; e_trap = 1; e_pcwr = 1;
               e_ack = '0;
               e_ack[e_k] = 1'b1;
               e_pc = m_mtvec & ~32'h3;
               if (m_mtvec[1:0] == 2'b01) e_pc = e_pc + 32'(4 * (16 + e_k));
            end
         end
      end
   endtask

   task automatic model_update();
      bit          ev = (e_kind != 0);
      bit [NI-1:0] clr = '0;
      if (csr_wr) begin
         case (csr_addr)
            12'h300: if (!ev) begin m_mie = csr_data[3]; m_mpie = csr_data[7]; end
            12'h304: m_en = csr_data[16 +: NI];
            12'h305: m_mtvec = {csr_data[31:2], (csr_data[1:0] < 2) ? csr_data[1:0] : m_mtvec[1:0]};
            12'h341: if (!ev) m_mepc = csr_data & ~32'h1;
            12'h342: if (!ev) m_mcause = csr_data;
            12'h343: if (!ev) m_mtval = csr_data;
            12'h344: clr = ~csr_data[16 +: NI];
            default: ;
         endcase
      end
      if (e_kind == 1 || e_kind == 3) begin
         m_mepc   = fet_pc & ~32'h1;
         m_mcause = (e_kind == 1) ? 32'(exc_cause) : (32'h8000_0000 | 32'(16 + e_k));
         m_mtval  = (e_kind == 1) ? exc_tval : 32'h0;
         m_mpie   = m_mie;
         m_mie    = 0;
      end else if (e_kind == 2) begin
         m_mie  = m_mpie;
         m_mpie = 1;
      end
      m_redir = ev;
      for (int k = 0; k < NI; k++) begin
         if (edge_mask[k]) begin
            if (m_s1[k] && !m_s2[k]) m_pend[k] = 1;
            else if (e_ack[k] || clr[k]) m_pend[k] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = irq;
   endtask

   // One clock: inputs are already driven; compare mid-cycle, then advance.
   task automatic step();
      predict();
      #2;
      obs_trap = trap_o; obs_pcwr = pc_wr_en_o; obs_pc = pc_o; obs_ack = irq_ack_o; obs_rd = csr_rd;
      check_eq("trap", 32'(trap_o), 32'(e_trap));
      check_eq("pc_wr_en", 32'(pc_wr_en_o), 32'(e_pcwr));
      if (e_pcwr) check_eq("pc", pc_o, e_pc);
      check_eq("irq_ack", 32'(irq_ack_o), 32'(e_ack));
      check_eq("csr_rdata", csr_rd, m_read(csr_addr));
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      csr_addr = a; csr_wr = 1'b1; csr_data = d;
      step();
      csr_wr = 1'b0;
   endtask

   task automatic csr_read(input logic [11:0] a, input string tag, input logic [31:0] exp);
      csr_addr = a; csr_wr = 1'b0;
      step();
      check_eq(tag, obs_rd, exp);
   endtask

   task automatic wait_trap(input string tag);
      bit got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         step();
         got = obs_trap;
      end
      check_eq({tag, "_taken"}, 32'(got), 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit [11:0] addrs [8];
      addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h340};
      edge_mask = EDGE;
      csr_addr = '0; csr_wr = 0; csr_data = '0; exc_valid = 0; exc_cause = '0;
      exc_tval = '0; mret = 0; fet_pc = '0; irq = '0;
      model_reset();

      // Outputs held low in reset even with active inputs
      #3;
      exc_valid = 1; mret = 1; csr_addr = 12'h305; irq = '1;
      #1;
      check_eq("rst_trap", 32'(trap_o), 32'h0);
      check_eq("rst_pcwr", 32'(pc_wr_en_o), 32'h0);
      check_eq("rst_rdata", csr_rd, 32'h0);
      exc_valid = 0; mret = 0; irq = '0;
      @(posedge clk); #1;
      rst_n = 1;
      csr_read(12'h300, "rst_mstatus", 32'h0000_1800);
      csr_read(12'h305, "rst_mtvec", 32'h0);
      csr_read(12'h344, "rst_mip", 32'h0);

      // Edge IRQ 0, direct mode
      fet_pc = 32'h0000_4444;
      csr_write(12'h305, 32'h100);
      csr_write(12'h300, 32'h8);
      csr_write(12'h304, 32'h0001_0000);
      irq = 8'h01; step();
      irq = 8'h00; step();
      check_eq("t1_early", 32'(obs_trap), 32'h0);
      step();
      check_eq("t1_trap", 32'(obs_trap), 32'h1);
      check_eq("t1_pc", obs_pc, 32'h100);
      check_eq("t1_ack", 32'(obs_ack), 32'h1);
      csr_read(12'h342, "t1_mcause", 32'h8000_0010);
      csr_read(12'h341, "t1_mepc", 32'h4444);
      csr_read(12'h300, "t1_mstatus", 32'h0000_1880);
      csr_read(12'h344, "t1_mip", 32'h0);

      // Vectored, two level lines; lowest wins
      irq = 8'b0010_1000;
      csr_write(12'h305, 32'h201);
      csr_write(12'h304, 32'h0028_0000);
      csr_write(12'h300, 32'h8);
      wait_trap("t2");
      check_eq("t2_pc", obs_pc, 32'h24C);
      check_eq("t2_ack", 32'(obs_ack), 32'h08);
      irq = '0;
      csr_read(12'h342, "t2_mcause", 32'h8000_0013);

      // Exception beats mret and an eligible edge IRQ
      csr_write(12'h304, 32'h0004_0000);
      csr_write(12'h300, 32'h8);
      irq = 8'h04; step();
      irq = 8'h00; step();
      exc_valid = 1; exc_cause = 5'd2; exc_tval = 32'hDEAD; mret = 1;
      step();
      check_eq("t3_trap", 32'(obs_trap), 32'h1);
      check_eq("t3_pc", obs_pc, 32'h200);
      check_eq("t3_ack", 32'(obs_ack), 32'h0);
      exc_valid = 0; mret = 0;
      csr_read(12'h342, "t3_mcause", 32'h2);
      csr_read(12'h343, "t3_mtval", 32'hDEAD);
      csr_read(12'h344, "t3_mip", 32'h0004_0000);

      // mret, then IRQ suppressed in the redirect shadow
      csr_write(12'h344, 32'h0);
      csr_write(12'h341, 32'h1234);
      csr_write(12'h300, 32'h80);
      irq = 8'h02;
      csr_write(12'h304, 32'h0002_0000);
      step();
      mret = 1; step();
      check_eq("t4_pcwr", 32'(obs_pcwr), 32'h1);
      check_eq("t4_trap", 32'(obs_trap), 32'h0);
      check_eq("t4_pc", obs_pc, 32'h1234);
      mret = 0;
      csr_read(12'h300, "t4_mstatus", 32'h0000_1888);
      check_eq("t4_shadow", 32'(obs_trap), 32'h0);
      step();
      check_eq("t4_trap2", 32'(obs_trap), 32'h1);
      check_eq("t4_pc2", obs_pc, 32'h244);
      check_eq("t4_ack", 32'(obs_ack), 32'h02);
      irq = '0;

      // WARL mtvec MODE, mepc[0]
      csr_write(12'h305, 32'h303);
      csr_read(12'h305, "t5_mtvec", 32'h301);
      csr_write(12'h341, 32'h7);
      csr_read(12'h341, "t5_mepc", 32'h6);

      // Asynchronous reset with an edge pending
      csr_write(12'h304, 32'h0001_0000);
      irq = 8'h01; step();
      irq = 8'h00; step();
      step();
      csr_read(12'h344, "t6_pend", 32'h0001_0000);
      #3;
      rst_n = 0;
      #1;
      check_eq("t6_rst_trap", 32'(trap_o), 32'h0);
      check_eq("t6_rst_rdata", csr_rd, 32'h0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
      csr_read(12'h344, "t6_mip", 32'h0);
      csr_write(12'h304, 32'h0001_0000);
      csr_write(12'h300, 32'h8);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("t6_notrap", 32'(obs_trap), 32'h0);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         csr_addr = addrs[$urandom_range(0, 7)];
         csr_wr   = ($urandom_range(0, 9) < 3);
         csr_data = $urandom;
         if (csr_addr == 12'h300 && $urandom_range(0, 1) == 1) csr_data[3] = 1'b1;
         exc_valid = ($urandom_range(0, 15) == 0);
         exc_cause = 5'($urandom);
         exc_tval  = $urandom;
         mret      = ($urandom_range(0, 11) == 0);
         fet_pc    = $urandom;
         if ($urandom_range(0, 3) == 0) irq = NI'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
